// File: rtl/concat_packer_if.sv
// Handshake bundle for concat_packer: field input side and packed-word output side.
// master = the environment driving fields and consuming words; slave = the packer.
interface concat_packer_if #(
  parameter int W = 3,
  parameter int N = 3
);
  localparam int CW = $clog2(N + 1);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic            rep_mode;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out_data;
  logic [CW-1:0]   out_count;

  modport master (
    output in_valid, in_data, in_last, rep_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, rep_mode, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/concat_packer.sv
// Packs W-bit fields into an N*W-bit word (first field in the MSBs), or replicates a
// single field N times; one word is held and presented until the consumer takes it.
module concat_packer #(
  parameter int W = 3,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  concat_packer_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*W-1:0] acc_q, acc_d;
  logic           mode_q, mode_d;
  logic           accept;
  logic           xfer;
  logic           rep;

  // The word register doubles as the output, so HOLD stability comes for free.
  assign bus.out_valid = (state_q == HOLD);
  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_data  = acc_q;
  assign bus.out_count = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;
  assign rep    = (state_q == IDLE) ? bus.rep_mode : mode_q;

  // NOTE: every next-state variable gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    if (xfer) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      mode_d  = 1'b0;
    end else if (accept) begin
      mode_d = rep;
      if (rep) begin
        acc_d   = {N{bus.in_data}};
        cnt_d   = CW'(N);
        state_d = HOLD;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) acc_d[(N-1-i)*W +: W] = bus.in_data;
        end
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1) || bus.in_last) ? HOLD : FILL;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end
endmodule

// File: doc/concat_packer.md
CONCAT_PACKER -- requirements
Module: concat_packer

Interface
REQ-001 The block SHALL provide parameter W, default 3, meaning width of one input field in bits (W >= 1).
REQ-002 The block SHALL provide parameter N, default 3, meaning fields per output word (N >= 2); output width is N*W.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_data/in_last/rep_mode valid this cycle.
REQ-007 in_ready  output  1  block accepts a field this cycle.
REQ-008 in_data  input  W  field value.
REQ-009 in_last  input  1  field closes the current word early.
REQ-010 rep_mode  input  1  0 = concatenate N fields; 1 = replicate one field N times.
REQ-011 out_valid  output  1  out_data/out_count hold a completed word.
REQ-012 out_ready  input  1  consumer takes the word this cycle.
REQ-013 out_data  output  N*W  packed word, first field in MSBs.
REQ-014 out_count  output  clog2(N+1)  number of valid fields in out_data.

Function
REQ-015 A field SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; an output word SHALL be transferred only in a cycle with out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL equal NOT out_valid (no same-cycle refill); max throughput is one word per N+1 cycles in concatenate mode.
REQ-017 The block SHALL use states IDLE (no fields held), FILL (1..N-1 fields held), HOLD (word presented, out_valid=1).
REQ-018 Mode SHALL be sampled from rep_mode on the first accepted field of a word (IDLE) and held until the word transfers; rep_mode in FILL SHALL be ignored.
REQ-019 Concatenate mode: the k-th accepted field (k=0..N-1) SHALL be written to out_data bits [(N-k)*W-1 : (N-1-k)*W]; unfilled positions SHALL be 0.
REQ-020 Concatenate mode: on acceptance of the N-th field, or of any field with in_last=1, the block SHALL enter HOLD on the next edge with out_count = fields in the word.
REQ-021 Replicate mode: a single accepted field SHALL produce out_data = field repeated N times and out_count = N, entering HOLD on the next edge; in_last is don't-care.
REQ-022 Transitions: IDLE->FILL on accept with word incomplete; IDLE->HOLD on accept completing the word (N=1 field with in_last, or replicate); FILL->HOLD on completing accept; HOLD->IDLE on output transfer.
REQ-023 In HOLD, out_data and out_count SHALL remain stable until transfer, regardless of in_valid, in_data, or rep_mode.
REQ-024 On output transfer the accumulator SHALL be cleared to 0 and the field counter to 0, so the next word starts zero-padded.
REQ-025 in_valid=0 in FILL SHALL hold state indefinitely (no timeout, no partial flush).
REQ-026 Latency SHALL be one cycle from the completing input accept to out_valid=1.

Reset
REQ-027 While rst=1 at a rising edge: state=IDLE, field counter=0, accumulator=0, held mode=0, out_valid=0, out_data=0, out_count=0; in_ready SHALL be 1 after the edge.
REQ-028 Reset mid-word (FILL or HOLD) SHALL discard the partial or pending word; no output transfer SHALL follow from pre-reset fields.
REQ-029 An input offered in the same cycle as rst=1 SHALL NOT be accepted.

Verification
REQ-030 W=3,N=3, rep_mode=0, fields 001,110,010, out_ready=1 -> out_data=9'b001_110_010, out_count=3, out_valid one cycle after third accept.
REQ-031 rep_mode=1, field 101 -> next cycle out_data=9'b101_101_101, out_count=3; rep_mode toggled during following FILL does not change that word's mode.
REQ-032 rep_mode=0, fields 101, 110 (in_last=1 on second) -> out_data=9'b101_110_000, out_count=2.
REQ-033 Word 100,101,110 with out_ready=0 for 5 cycles -> out_valid=1, out_data=9'b100_101_110 stable, in_ready=0 throughout; accept completes on first out_ready=1, in_ready=1 next cycle.
REQ-034 Accept field 111, assert rst one cycle, then fields 001,010,011 -> single output 9'b001_010_011, count 3; 111 never appears.
REQ-035 Parameter sweep W=4,N=2: fields 1010,0101 -> out_data=8'b1010_0101; replicate 0011 -> 8'b0011_0011.
